btn_temp_conditioner: RTL and testbench

BTN_TEMP_CONDITIONER -- requirements
Module: btn_temp_conditioner

---
 rtl/btn_temp_conditioner.sv | 153 +++++++++++++++
 tb/tb_btn_temp_conditioner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/btn_temp_conditioner.sv
// Button and temperature-code input conditioner.
// The raw push-button is synchronized and debounced by a four-state FSM that
// produces a level and a one-cycle press event. The raw 2-bit temperature code
// is synchronized and only accepted once it has been stable for TEMP_STABLE
// samples. The two paths share nothing but the clock and reset.
module btn_temp_conditioner #(
  parameter int DB_CYCLES   = 16,
  parameter int TEMP_STABLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bt_raw,
  input  logic [1:0] temp_raw,
  output logic       bt_pulse,
  output logic       bt_level,
  output logic [1:0] temp,
  output logic       temp_changed,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int TW = $clog2(TEMP_STABLE + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TEMP_STABLE - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } bt_state_t;

  bt_state_t       state;
  logic [CW-1:0]   cnt;

  logic            bt_meta;
  logic            bt_sync;
  logic [1:0]      temp_meta;
  logic [1:0]      temp_sync;

  logic [1:0]      cand;
  logic [TW-1:0]   tcnt;

  // Two-flop synchronizers bring the asynchronous inputs into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      bt_meta   <= 1'b0;
      bt_sync   <= 1'b0;
      temp_meta <= 2'b00;
      temp_sync <= 2'b00;
    end else begin
      bt_meta   <= bt_raw;
      bt_sync   <= bt_meta;
      temp_meta <= temp_raw;
      temp_sync <= temp_meta;
    end
  end

  // Button debounce FSM; the level and press pulse are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bt_level <= 1'b0;
      bt_pulse <= 1'b0;
    end else begin
      bt_pulse <= 1'b0;
      case (state)
        IDLE: begin
          bt_level <= 1'b0;
          if (bt_sync) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!bt_sync) begin
            state    <= IDLE;
            cnt      <= '0;
            bt_level <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= PRESSED;
            cnt      <= '0;
            bt_level <= 1'b1;
            bt_pulse <= 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            bt_level <= 1'b0;
          end
        end
        PRESSED: begin
          bt_level <= 1'b1;
          if (!bt_sync) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (bt_sync) begin
            state    <= PRESSED;
            cnt      <= '0;
            bt_level <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            bt_level <= 1'b0;
          end else begin
            cnt      <= cnt + 1'b1;
            bt_level <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bt_level <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

  // Temperature filter: a candidate code must persist TEMP_STABLE samples before it replaces temp.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand         <= 2'b00;
      tcnt         <= '0;
      temp         <= 2'b00;
      temp_changed <= 1'b0;
    end else begin
      temp_changed <= 1'b0;
      if (temp_sync == temp) begin
        cand <= temp;
        tcnt <= '0;
      end else if (temp_sync != cand) begin
        cand <= temp_sync;
        tcnt <= TW'(1);
      end else if (tcnt == TCNT_LAST) begin
        temp         <= cand;
        tcnt         <= '0;
        temp_changed <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_temp_conditioner.sv
// Self-checking bench for btn_temp_conditioner with DB_CYCLES=4, TEMP_STABLE=3.
// A per-cycle vector table covers a simultaneous press/temp change and release;
// hand-written sequences cover glitch rejection, reset mid-debounce and short temp codes.
module tb_btn_temp_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       bt_raw;
  logic [1:0] temp_raw;
  logic       bt_pulse;
  logic       bt_level;
  logic [1:0] temp;
  logic       temp_changed;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       bt;
    logic [1:0] tr;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[16];

  btn_temp_conditioner #(
    .DB_CYCLES  (4),
    .TEMP_STABLE(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bt_raw      (bt_raw),
    .temp_raw    (temp_raw),
    .bt_pulse    (bt_pulse),
    .bt_level    (bt_level),
    .temp        (temp),
    .temp_changed(temp_changed),
    .state_dbg   (state_dbg)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {state_dbg, bt_level, bt_pulse, temp, temp_changed};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic bt, input logic [1:0] tr);
    bt_raw   = bt;
    temp_raw = tr;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic applyReset();
    bt_raw   = 1'b0;
    temp_raw = 2'b00;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Main test sequence.
  initial begin
    bit seen_pw;

    // {bt_raw, temp_raw, expected {state_dbg, bt_level, bt_pulse, temp, temp_changed}}
    vecs[0]  = '{1'b1, 2'b10, 7'b00_0_0_00_0};
    vecs[1]  = '{1'b1, 2'b10, 7'b00_0_0_00_0};
    vecs[2]  = '{1'b1, 2'b10, 7'b01_0_0_00_0};
    vecs[3]  = '{1'b1, 2'b10, 7'b01_0_0_00_0};
    vecs[4]  = '{1'b1, 2'b10, 7'b01_0_0_10_1};
    vecs[5]  = '{1'b1, 2'b10, 7'b10_1_1_10_0};
    vecs[6]  = '{1'b1, 2'b10, 7'b10_1_0_10_0};
    vecs[7]  = '{1'b1, 2'b10, 7'b10_1_0_10_0};
    vecs[8]  = '{1'b0, 2'b00, 7'b10_1_0_10_0};
    vecs[9]  = '{1'b0, 2'b00, 7'b10_1_0_10_0};
    vecs[10] = '{1'b0, 2'b00, 7'b11_1_0_10_0};
    vecs[11] = '{1'b0, 2'b00, 7'b11_1_0_10_0};
    vecs[12] = '{1'b0, 2'b00, 7'b11_1_0_00_1};
    vecs[13] = '{1'b0, 2'b00, 7'b00_0_0_00_0};
    vecs[14] = '{1'b0, 2'b00, 7'b00_0_0_00_0};
    vecs[15] = '{1'b0, 2'b00, 7'b00_0_0_00_0};

    applyReset();
    checkOutput("reset_state", outs(), 7'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].bt, vecs[i].tr);
      checkOutput($sformatf("vec_%0d", i), outs(), vecs[i].exp);
    end

    // Bouncing button: 3 high, 2 low, five times; never accepted.
    applyReset();
    seen_pw = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        applyStimulus(c < 3, 2'b00);
        checkOutput($sformatf("bounce_r%0d_c%0d", r, c),
                    {4'b0, state_dbg[1], bt_level, bt_pulse}, 7'b0);
        if (state_dbg == 2'b01) seen_pw = 1'b1;
      end
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 2'b00);
      checkOutput("bounce_tail", {state_dbg, bt_level, bt_pulse, 3'b0}, 7'b0);
    end
    checkOutput("bounce_saw_press_wait", {6'b0, seen_pw}, 7'b1);

    // Release glitch of two cycles keeps the button pressed.
    applyReset();
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 2'b00);
    checkOutput("held_pressed", {state_dbg, bt_level, bt_pulse, 3'b0}, 7'b10_1_0_000);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c >= 2, 2'b00);
      checkOutput($sformatf("rel_glitch_%0d", c), {5'b0, bt_level, bt_pulse}, 7'b0000010);
    end
    checkOutput("rel_glitch_end", {state_dbg, 5'b0}, 7'b10_00000);

    // Short temp excursion (2 cycles) back to current value: no change, no strobe.
    applyReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, (c < 2) ? 2'b01 : 2'b00);
      checkOutput($sformatf("temp_short_%0d", c), {4'b0, temp, temp_changed}, 7'b0);
    end

    // Reset mid-debounce aborts, then a full debounce is needed again.
    applyReset();
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 2'b00);
    checkOutput("pre_reset_press_wait", {state_dbg, bt_level, bt_pulse, 3'b0}, 7'b01_0_0_000);
    reset = 1'b1;
    tick();
    checkOutput("mid_reset", {state_dbg, bt_level, bt_pulse, 3'b0}, 7'b0);
    reset = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 6)
        checkOutput("post_reset_pulse", {state_dbg, bt_level, bt_pulse, 3'b0}, 7'b10_1_1_000);
      else
        checkOutput($sformatf("post_reset_edge_%0d", c), {6'b0, bt_pulse}, 7'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
